// File: rtl/md_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// The E stage drives the issue fields; the unit returns Busy and the architectural HI/LO.
interface md_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, MDOp, A, B, input Busy, HI, LO);
    modport slave  (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// The result is computed at issue and parked in tHI/tLO; the down-counter only models latency.
//
// state | meaning
// IDLE  | ready; accepts mult/div (enter RUN) or mthi/mtlo (write at once)
// RUN   | latency countdown; HI/LO are committed on the edge where cnt==1
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      t_hi, t_lo, hi, lo;
    logic             div0;
    logic             accept, is_mul, is_div, is_sgn, commit;
    logic [63:0]      ext_a, ext_b, prod;
    logic             neg_a, neg_b;
    logic [31:0]      mag_a, mag_b, uq, ur, quo, rem;

    // Operand decode and the datapath, evaluated against the operands present at issue.
    always_comb begin
        accept = (state == IDLE) && bus.Start;
        is_mul = (bus.MDOp == 3'd0) || (bus.MDOp == 3'd1);
        is_div = (bus.MDOp == 3'd2) || (bus.MDOp == 3'd3);
        is_sgn = ~bus.MDOp[0];

        ext_a = {{32{is_sgn & bus.A[31]}}, bus.A};
        ext_b = {{32{is_sgn & bus.B[31]}}, bus.B};
        prod  = ext_a * ext_b;

        // Divide magnitudes and fix signs afterwards; 0x80000000 / -1 wraps to 0x80000000.
        neg_a = is_sgn & bus.A[31];
        neg_b = is_sgn & bus.B[31];
        mag_a = neg_a ? (32'd0 - bus.A) : bus.A;
        mag_b = neg_b ? (32'd0 - bus.B) : bus.B;
        uq    = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
        ur    = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
        quo   = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem   = neg_a ? (32'd0 - ur) : ur;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mul) begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_W'(MULT_CYCLES);
                end else if (accept && is_div) begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_W'(DIV_CYCLES);
                end
            end
            RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_hi <= '0;
            t_lo <= '0;
            div0 <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (accept && is_mul) begin
                t_hi <= prod[63:32];
                t_lo <= prod[31:0];
                div0 <= 1'b0;
            end else if (accept && is_div) begin
                t_hi <= rem;
                t_lo <= quo;
                div0 <= (bus.B == 32'd0);
            end

            if (commit) begin
                if (!div0) begin
                    hi <= t_hi;
                    lo <= t_lo;
                end
            end else if (accept && bus.MDOp == 3'd4) begin
                hi <= bus.A;
            end else if (accept && bus.MDOp == 3'd5) begin
                lo <= bus.A;
            end
        end
    end

    assign bus.Busy = (state == RUN);
    assign bus.HI   = hi;
    assign bus.LO   = lo;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against a
// 64-bit arithmetic model of HI/LO and the fixed busy latency.
module tb_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: architectural effect of one op and its busy length.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo, output int n);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = 0;
        case (op)
            3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; n = MULT_N; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; n = MULT_N; end
            3'd2: begin
                n = DIV_N;
                if (b != 32'd0) begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end
            end
            3'd3: begin
                n = DIV_N;
                if (b != 32'd0) begin lo = a / b; hi = a % b; end
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: n = 0;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the commit edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        model(op, a, b, m_hi, m_lo, n);
        bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
        for (int i = 0; i < n; i++) begin
            check("busy_run", {31'd0, bus.Busy}, 32'd1);
            check("hi_hold", bus.HI, old_hi);
            check("lo_hold", bus.LO, old_lo);
            // Stray issue while running must be ignored.
            if (i == 1) begin
                bus.Start = 1'b1; bus.MDOp = 3'($urandom_range(0, 5)); bus.A = $urandom;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
        end
        bus.Start = 1'b0;
        check("busy_done", {31'd0, bus.Busy}, 32'd0);
        check("hi_result", bus.HI, m_hi);
        check("lo_result", bus.LO, m_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        reset = 1'b0;
        bus.Start = 1'b0; bus.MDOp = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
        #3;
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFFA);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi", bus.HI, 32'hFFFF_FFFE);
        check("multu_lo", bus.LO, 32'h0000_0001);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_hi", bus.HI, 32'hFFFF_FFFF);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        check("divu_lo", bus.LO, 32'h7FFF_FFFC);
        check("divu_hi", bus.HI, 32'h0000_0001);

        run_op(3'd4, 32'h0000_1234, 32'd0);
        check("mthi_hi", bus.HI, 32'h0000_1234);
        run_op(3'd5, 32'h0000_5678, 32'd0);
        check("mtlo_lo", bus.LO, 32'h0000_5678);

        run_op(3'd2, 32'd55, 32'd0);
        check("div0_hi", bus.HI, 32'h0000_1234);
        check("div0_lo", bus.LO, 32'h0000_5678);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo", bus.LO, 32'h8000_0000);
        check("ovf_hi", bus.HI, 32'h0000_0000);

        run_op(3'd6, 32'hAAAA_AAAA, 32'h5555_5555);
        run_op(3'd7, 32'hBBBB_BBBB, 32'h1);

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) a = 32'($signed(32'($urandom_range(0, 200))) - 100);
            run_op(op, a, b);
        end

        // Abort: DIV 100/7, stray MTHI at busy cycle 3, reset at busy cycle 6.
        bus.Start = 1'b1; bus.MDOp = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("abort_busy", {31'd0, bus.Busy}, 32'd1);
            check("abort_hi_hold", bus.HI, m_hi);
            check("abort_lo_hold", bus.LO, m_lo);
            if (i == 2) begin
                bus.Start = 1'b1; bus.MDOp = 3'd4; bus.A = 32'h0000_DEAD;
            end else begin
                bus.Start = 1'b0;
            end
            if (i == 5) begin
                #2 reset = 1'b0;
                #1;
                m_hi = 32'd0;
                m_lo = 32'd0;
                check("abort_rst_busy", {31'd0, bus.Busy}, 32'd0);
                check("abort_rst_hi", bus.HI, 32'd0);
                check("abort_rst_lo", bus.LO, 32'd0);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_busy", {31'd0, bus.Busy}, 32'd0);
            check("post_hi", bus.HI, 32'd0);
            check("post_lo", bus.LO, 32'd0);
        end

        run_op(3'd1, 32'd100, 32'd7);
        check("after_rst_lo", bus.LO, 32'd700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the E stage of the 5-stage pipeline. It is the stall *source* that the hazard unit consumes. It accepts one mult/multu/div/divu/mthi/mtlo per issue and holds `Busy` for a fixed latency. The hazard unit combines `Start | Busy` with the D-stage instruction class to freeze any HI/LO-touching instruction in D. `mfhi`/`mflo` in E read `HI`/`LO` directly.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `Start`  in  1  issue strobe from E stage, one cycle per instruction, already qualified by not-stalled/not-flushed
- `MDOp`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (no-op)
- `A`  in  32  forwarded rs value
- `B`  in  32  forwarded rt value
- `Busy`  out  1  operation in progress
- `HI`  out  32  architectural HI
- `LO`  out  32  architectural LO

## Operation
- State: `IDLE`, `RUN`. There is a down-counter `cnt` (4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES)). Result temporaries are `tHI` and `tLO`.
- IDLE, `Start` with MULT/MULTU:
  - Compute the 64-bit product of `A`×`B` (signed or unsigned) into `{tHI,tLO}`.
  - Load `cnt=MULT_CYCLES`, go to RUN.
- IDLE, `Start` with DIV/DIVU:
  - Set `tLO` = quotient and `tHI` = remainder.
  - Signed division truncates toward zero. The remainder takes the sign of the dividend.
  - Load `cnt=DIV_CYCLES`, go to RUN.
- Divide by zero (`B==0`): the op still runs the full DIV_CYCLES and sets `Busy`. HI and LO are left unchanged at commit. A flag is latched at start to suppress the commit.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- IDLE, `Start` with MTHI: `HI<=A` at that edge. MTLO: `LO<=A` at that edge. State stays IDLE and `Busy` is never raised.
- RUN: `cnt` decrements each edge. At the edge where `cnt==1`: HI/LO are committed from the temporaries, `cnt` goes to 0, and the state returns to IDLE.
- `Busy` = (state==RUN).
- `Start` while RUN is ignored: no effect on temporaries, counter or HI/LO. The hazard unit guarantees this never happens, and the bench checks it is harmless.
- Reserved `MDOp` with `Start` has no effect.
- Reset (async, low): state=IDLE, cnt=0, HI=0, LO=0, tHI=tLO=0, `Busy`=0. Reset asserted mid-RUN aborts the op with no commit.

## Timing
- Reset values of all outputs: `Busy`=0, `HI`=0, `LO`=0.
- Start captured at edge k:
  - `Busy` is high from after edge k until after edge k+N−1, which is exactly N cycles, where N is MULT_CYCLES or DIV_CYCLES.
  - Edge k+N commits HI/LO and drops `Busy`.
  - New HI/LO are visible in the cycle after edge k+N.
- A new `Start` is accepted at edge k+N+1 at the earliest. This is the first cycle with `Busy`=0.
- MTHI/MTLO: the value is visible in the cycle after the start edge. Latency is 1, with no busy.
- `Busy` and `HI`/`LO` are registered outputs with no combinational path from inputs. The hazard unit is responsible for combining with `Start` in the same cycle.

## Test plan
- Reset, then MULT A=0xFFFFFFFE (−2), B=3 at edge 1 → `Busy`=1 for 5 cycles. After edge 6, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles, HI=0xFFFFFFFE and LO=0x00000001.
- DIV A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU with the same operands gives LO=0x7FFFFFFC and HI=1.
- MTHI A=0x1234 then MTLO A=0x5678 on consecutive cycles → HI=0x1234 and LO=0x5678 one cycle after each, with `Busy` never asserted. Then DIV B=0 runs 10 busy cycles and HI/LO stay 0x1234/0x5678.
- DIV 100/7 started, `Start`+MTHI A=0xDEAD pulsed at busy cycle 3, reset pulsed low at busy cycle 6 → MTHI ignored, `Busy`, HI and LO go to 0 immediately on reset, and no commit ever occurs.
